// File: rtl/pipeline_reg_ex_wb_pkg.sv
// Shared constants and the EX/WB bundle layout for the execute-to-writeback boundary.
package pipeline_reg_ex_wb_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int CTRL_WIDTH     = 2;

    typedef struct packed {
        logic                      regwrite;
        logic                      memtoreg;
        logic [DATA_WIDTH-1:0]     alu_result;
        logic [DATA_WIDTH-1:0]     mem_data;
        logic [REG_ADDR_WIDTH-1:0] rd;
    } ex_wb_t;

endpackage

// File: rtl/pipeline_reg_ex_wb_pipe_reg.sv
// Generic pipeline register: captures d every rising edge, clears to zero on synchronous reset.
module pipe_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clock) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipeline_reg_ex_wb.sv
// EX/WB pipeline boundary: packs writeback control and data into one bundle, registers it, unpacks it.
module pipeline_reg_ex_wb #(
    parameter int DATA_WIDTH     = pipeline_reg_ex_wb_pkg::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = pipeline_reg_ex_wb_pkg::REG_ADDR_WIDTH
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      regwrite_in,
    input  logic                      memtoreg_in,
    input  logic [DATA_WIDTH-1:0]     alu_result_in,
    input  logic [DATA_WIDTH-1:0]     mem_data_in,
    input  logic [REG_ADDR_WIDTH-1:0] rd_in,
    output logic                      regwrite_out,
    output logic                      memtoreg_out,
    output logic [DATA_WIDTH-1:0]     alu_result_out,
    output logic [DATA_WIDTH-1:0]     mem_data_out,
    output logic [REG_ADDR_WIDTH-1:0] rd_out
);

    import pipeline_reg_ex_wb_pkg::*;

    localparam int BUNDLE_WIDTH = CTRL_WIDTH + 2 * DATA_WIDTH + REG_ADDR_WIDTH;

    logic [BUNDLE_WIDTH-1:0] bundle_d;
    logic [BUNDLE_WIDTH-1:0] bundle_q;

    // rd = x0 is passed through untouched; the register file discards those writes.
    assign bundle_d = {regwrite_in, memtoreg_in, alu_result_in, mem_data_in, rd_in};

    pipe_reg #(
        .WIDTH(BUNDLE_WIDTH)
    ) u_pipe_reg (
        .clock(clock),
        .reset(reset),
        .d    (bundle_d),
        .q    (bundle_q)
    );

    assign {regwrite_out, memtoreg_out, alu_result_out, mem_data_out, rd_out} = bundle_q;

endmodule

// File: tb/tb_pipeline_reg_ex_wb.sv
// Directed self-checking bench for the EX/WB pipeline register.
module tb_pipeline_reg_ex_wb;

    logic        clock;
    logic        reset;
    logic        regwrite_in;
    logic        memtoreg_in;
    logic [31:0] alu_result_in;
    logic [31:0] mem_data_in;
    logic [4:0]  rd_in;
    logic        regwrite_out;
    logic        memtoreg_out;
    logic [31:0] alu_result_out;
    logic [31:0] mem_data_out;
    logic [4:0]  rd_out;

    int checkCount;
    int failCount;

    pipeline_reg_ex_wb #(
        .DATA_WIDTH    (32),
        .REG_ADDR_WIDTH(5)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .regwrite_in   (regwrite_in),
        .memtoreg_in   (memtoreg_in),
        .alu_result_in (alu_result_in),
        .mem_data_in   (mem_data_in),
        .rd_in         (rd_in),
        .regwrite_out  (regwrite_out),
        .memtoreg_out  (memtoreg_out),
        .alu_result_out(alu_result_out),
        .mem_data_out  (mem_data_out),
        .rd_out        (rd_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rw, input logic mtr, input logic [31:0] alu,
                                 input logic [31:0] mem, input logic [4:0] rd);
        regwrite_in   = rw;
        memtoreg_in   = mtr;
        alu_result_in = alu;
        mem_data_in   = mem;
        rd_in         = rd;
    endtask

    task automatic stepCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic checkAll(input string tag, input logic rw, input logic mtr,
                            input logic [31:0] alu, input logic [31:0] mem, input logic [4:0] rd);
        checkOutput({tag, ".regwrite"},   {31'd0, regwrite_out}, {31'd0, rw});
        checkOutput({tag, ".memtoreg"},   {31'd0, memtoreg_out}, {31'd0, mtr});
        checkOutput({tag, ".alu_result"}, alu_result_out,        alu);
        checkOutput({tag, ".mem_data"},   mem_data_out,          mem);
        checkOutput({tag, ".rd"},         {27'd0, rd_out},       {27'd0, rd});
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;

        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        stepCycle();
        checkAll("reset_zero_in", 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);

        // Reset must win over capture even with live inputs.
        applyStimulus(1'b1, 1'b1, 32'h55, 32'h66, 5'd9);
        stepCycle();
        checkAll("reset_live_in", 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);

        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h30, 32'h0, 5'd5);
        #2;
        checkAll("rtype_pre_edge", 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        stepCycle();
        checkAll("rtype", 1'b1, 1'b0, 32'h30, 32'h0, 5'd5);

        applyStimulus(1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 5'd3);
        stepCycle();
        checkAll("load", 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 5'd3);

        applyStimulus(1'b0, 1'b0, 32'h200, 32'hCAFEBABE, 5'd0);
        stepCycle();
        checkAll("store", 1'b0, 1'b0, 32'h200, 32'hCAFEBABE, 5'd0);

        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 5'd1);
        stepCycle();
        checkAll("seq_add", 1'b1, 1'b0, 32'h10, 32'h0, 5'd1);
        applyStimulus(1'b1, 1'b1, 32'h40, 32'h12345678, 5'd2);
        stepCycle();
        checkAll("seq_lw", 1'b1, 1'b1, 32'h40, 32'h12345678, 5'd2);
        applyStimulus(1'b1, 1'b0, 32'hFFFFFFF0, 32'h0, 5'd3);
        stepCycle();
        checkAll("seq_sub", 1'b1, 1'b0, 32'hFFFFFFF0, 32'h0, 5'd3);
        applyStimulus(1'b0, 1'b0, 32'h44, 32'h0000BEEF, 5'd0);
        stepCycle();
        checkAll("seq_sw", 1'b0, 1'b0, 32'h44, 32'h0000BEEF, 5'd0);

        applyStimulus(1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31);
        stepCycle();
        checkAll("all_ones", 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31);

        applyStimulus(1'b1, 1'b0, 32'h12345678, 32'h0, 5'd0);
        stepCycle();
        checkAll("rd_x0", 1'b1, 1'b0, 32'h12345678, 32'h0, 5'd0);

        applyStimulus(1'b1, 1'b1, 32'hCCCCCCCC, 32'hDDDDDDDD, 5'd11);
        stepCycle();
        checkAll("mid_valid", 1'b1, 1'b1, 32'hCCCCCCCC, 32'hDDDDDDDD, 5'd11);
        reset = 1'b1;
        #2;
        checkAll("mid_reset_sync", 1'b1, 1'b1, 32'hCCCCCCCC, 32'hDDDDDDDD, 5'd11);
        stepCycle();
        checkAll("mid_reset", 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h0000ABCD, 32'h00000001, 5'd7);
        stepCycle();
        checkAll("post_reset", 1'b1, 1'b0, 32'h0000ABCD, 32'h00000001, 5'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/pipeline_reg_ex_wb.md
Name: pipeline_reg_ex_wb

Overview:
- Pipeline boundary register between the execute/memory stage and the writeback stage of the RISC-V core.
- Captures the writeback control bits, the ALU result, the loaded memory data and the destination register index on every rising clock edge.
- Presents them to the writeback mux and the register-file write port one cycle later.
- Purely a register: no data transformation, no filtering of rd = x0. The register file ignores writes to x0.

Parameters:
- DATA_WIDTH, 32, width of alu_result and mem_data paths.
- REG_ADDR_WIDTH, 5, width of the destination register index.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- regwrite_in  input  1  register-file write enable from the EX stage.
- memtoreg_in  input  1  writeback source select from the EX stage (1 = memory data, 0 = ALU result).
- alu_result_in  input  DATA_WIDTH  ALU result / computed address.
- mem_data_in  input  DATA_WIDTH  data read from data memory.
- rd_in  input  REG_ADDR_WIDTH  destination register index.
- regwrite_out  output  1  registered regwrite_in.
- memtoreg_out  output  1  registered memtoreg_in.
- alu_result_out  output  DATA_WIDTH  registered alu_result_in.
- mem_data_out  output  DATA_WIDTH  registered mem_data_in.
- rd_out  output  REG_ADDR_WIDTH  registered rd_in.

Behaviour:
- One clock (clock); reset is synchronous and active-high (reset). Both are fixed.
- All outputs are driven directly from flip-flops. There is no combinational path from any input to any output.
- Reset: on a rising edge with reset = 1, every output becomes 0:
  - regwrite_out = 0, memtoreg_out = 0
  - alu_result_out = 0, mem_data_out = 0, rd_out = 0
- Reset takes priority over input capture on the same edge.
- Reset asserted mid-stream clears the register at the next edge. The in-flight instruction is discarded, which is equivalent to a bubble with no writeback.
- Reset does not act asynchronously. Outputs hold their values until the next rising edge.
- Normal operation: on each rising edge with reset = 0, each output takes its corresponding input value sampled at that edge.
- Latency is exactly 1 cycle. There is no enable, stall or handshake; a new value is captured every cycle.
- All fields are captured unconditionally, regardless of control-bit values:
  - regwrite = 0 (store, bubble): alu_result, mem_data and rd still propagate.
  - rd = 0 with regwrite = 1: propagates unchanged.
- Values are bit-exact pass-through. All-ones (0xFFFFFFFF, rd = 31) and all-zeros are preserved. No sign or width conversion.
- Output is undefined before the first clock edge. The bench must apply reset for at least one rising edge.

Decomposition:
- Shared core package: DATA_WIDTH (32) and REG_ADDR_WIDTH (5) constants, plus an optional packed struct ex_wb_t holding {regwrite, memtoreg, alu_result, mem_data, rd}.
- Natural sub-module: a generic pipe_reg (parameterised width, sync active-high reset to 0), instantiated once over the concatenated bundle. This module adds field packing and unpacking only.

Test Plan:
- Reset: hold reset = 1 over one edge with inputs 0 -> every output is 0. Repeat with non-zero inputs (regwrite = 1, rd = 9, alu = 0x55) -> outputs are still 0.
- R-type: regwrite = 1, memtoreg = 0, alu = 0x30, rd = 5 -> after one edge, outputs are 1, 0, 0x30, rd = 5. Outputs are unchanged before that edge.
- Load: regwrite = 1, memtoreg = 1, alu = 0x100, mem = 0xDEADBEEF, rd = 3 -> mem_data_out = 0xDEADBEEF, memtoreg_out = 1, rd_out = 3.
- Store then back-to-back sequence:
  - Store: regwrite = 0, alu = 0x200, mem = 0xCAFEBABE, rd = 0 -> regwrite_out = 0.
  - Sequence ADD(rd1, 0x10) / LW(rd2, 0x12345678) / SUB(rd3, 0xFFFFFFF0) / SW -> each appears exactly one cycle later, ending with regwrite_out = 0.
- Boundaries:
  - alu = mem = 0xFFFFFFFF, rd = 31 -> outputs all-ones, rd_out = 31.
  - regwrite = 1, rd = 0, alu = 0x12345678 -> regwrite_out = 1, rd_out = 0.
- Mid-stream reset: with valid data registered (alu = 0xCCCCCCCC, mem = 0xDDDDDDDD, rd = 11), assert reset for one edge -> all outputs 0. Deassert -> the next input is captured normally.
